// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: two-road traffic light phase scheduler with holds, pause and BCD countdown
module traffic_phase_sched #(
  parameter int GA = 25,
  parameter int YA = 5,
  parameter int GB = 15,
  parameter int YB = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       start,
  input  logic       stopa,
  input  logic       stopb,
  input  logic       pause,
  output logic       r1,
  output logic       y1,
  output logic       g1,
  output logic       r2,
  output logic       y2,
  output logic       g2,
  output logic [2:0] phase,
  output logic [7:0] remain
);
  typedef enum logic [2:0] {IDLE = 3'd0, AG = 3'd1, AY = 3'd2, BG = 3'd3, BY = 3'd4} state_t;
  state_t     r_state, w_nstate;
  logic [6:0] r_cnt, w_ncnt;
  logic       w_hold_a, w_hold_b, w_exp;
  logic [3:0] w_tens, w_units;
  // next state and countdown: start=0 > IDLE entry > pause > holds > tick
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_hold_a = stopa;
    w_hold_b = stopb & ~stopa;
    w_exp    = tick & (r_cnt <= 7'd1);
    if (!start) begin
      w_nstate = IDLE;
      w_ncnt   = '0;
    end else if (r_state == IDLE) begin
      w_nstate = AG;
      w_ncnt   = 7'(GA);
    end else if (!pause) begin
      case (r_state)
        AG: begin
          if (w_hold_b) begin
            w_nstate = AY;
            w_ncnt   = 7'(YA);
          end else if (!w_hold_a && tick) begin
            w_nstate = w_exp ? AY : AG;
            w_ncnt   = w_exp ? 7'(YA) : r_cnt - 7'd1;
          end
        end
        AY: begin
          if (tick) begin
            w_nstate = !w_exp ? AY : (w_hold_a ? AG : BG);
            w_ncnt   = !w_exp ? r_cnt - 7'd1 : (w_hold_a ? 7'(GA) : 7'(GB));
          end
        end
        BG: begin
          if (w_hold_a) begin
            w_nstate = BY;
            w_ncnt   = 7'(YB);
          end else if (!w_hold_b && tick) begin
            w_nstate = w_exp ? BY : BG;
            w_ncnt   = w_exp ? 7'(YB) : r_cnt - 7'd1;
          end
        end
        BY: begin
          if (tick) begin
            w_nstate = !w_exp ? BY : (w_hold_b ? BG : AG);
            w_ncnt   = !w_exp ? r_cnt - 7'd1 : (w_hold_b ? 7'(GB) : 7'(GA));
          end
        end
        default: begin
          w_nstate = IDLE;
          w_ncnt   = '0;
        end
      endcase
    end
    w_tens  = 4'(w_ncnt / 7'd10);
    w_units = 4'(w_ncnt % 7'd10);
  end
  // state, counter and all outputs registered from the next-state values
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      phase   <= 3'd0;
      remain  <= 8'h00;
      r1      <= 1'b1;
      y1      <= 1'b0;
      g1      <= 1'b0;
      r2      <= 1'b1;
      y2      <= 1'b0;
      g2      <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      phase   <= w_nstate;
      remain  <= {w_tens, w_units};
      r1      <= (w_nstate == IDLE) | (w_nstate == BG) | (w_nstate == BY);
      y1      <= (w_nstate == AY);
      g1      <= (w_nstate == AG);
      r2      <= (w_nstate == IDLE) | (w_nstate == AG) | (w_nstate == AY);
      y2      <= (w_nstate == BY);
      g2      <= (w_nstate == BG);
    end
  end
endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb_traffic_phase_sched: directed scenarios plus random stimulus against a phase-table reference model
module tb_traffic_phase_sched;
  localparam int GA = 25, YA = 5, GB = 15, YB = 5;
  logic clk = 1'b0, clr, tick = 1'b0, start = 1'b0, stopa = 1'b0, stopb = 1'b0, pause = 1'b0;
  logic r1, y1, g1, r2, y2, g2;
  logic [2:0] phase;
  logic [7:0] remain;
  int n_chk = 0, n_fail = 0;
  int m_ph = 0, m_cnt = 0;
  int dur[5] = '{0, GA, YA, GB, YB};
  logic [5:0] lamp_tab[5] = '{6'b100100, 6'b001100, 6'b010100, 6'b100001, 6'b100010};

  traffic_phase_sched #(.GA(GA), .YA(YA), .GB(GB), .YB(YB)) dut (
    .clk(clk), .clr(clr), .tick(tick), .start(start), .stopa(stopa), .stopb(stopb), .pause(pause),
    .r1(r1), .y1(y1), .g1(g1), .r2(r2), .y2(y2), .g2(g2), .phase(phase), .remain(remain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int c);
    return 8'(((c / 10) << 4) | (c % 10));
  endfunction

  task automatic check_model();
    chk("phase", {5'b0, phase}, 8'(m_ph));
    chk("remain", remain, bcd(m_cnt));
    chk("lamps", {2'b0, r1, y1, g1, r2, y2, g2}, {2'b0, lamp_tab[m_ph]});
  endtask

  // reference: phases cycle 1..4 with a duration table; holds redirect or freeze greens
  task automatic model_step();
    bit ha, hb;
    int nxt;
    ha = stopa;
    hb = stopb && !stopa;
    if (!clr || !start) begin
      m_ph = 0; m_cnt = 0;
    end else if (m_ph == 0) begin
      m_ph = 1; m_cnt = GA;
    end else if (!pause) begin
      if (ha && m_ph == 3) begin
        m_ph = 4; m_cnt = YB;
      end else if (hb && m_ph == 1) begin
        m_ph = 2; m_cnt = YA;
      end else if (!(ha && m_ph == 1) && !(hb && m_ph == 3) && tick) begin
        if (m_cnt > 1) m_cnt--;
        else begin
          nxt = m_ph % 4 + 1;
          if (ha && m_ph == 2) nxt = 1;
          if (hb && m_ph == 4) nxt = 3;
          m_ph = nxt;
          m_cnt = dur[nxt];
        end
      end
    end
  endtask

  task automatic cyc();
    logic [2:0] pd;
    pd = phase;
    @(posedge clk);
    model_step();
    #1;
    check_model();
    chk("handover", 8'((pd == 3'd1 && phase == 3'd3) || (pd == 3'd3 && phase == 3'd1)), 8'd0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
    end
  endtask

  initial begin
    clr = 1'b1;
    #1 clr = 1'b0;
    #11;
    chk("rst_phase", {5'b0, phase}, 8'h00);
    chk("rst_remain", remain, 8'h00);
    chk("rst_lamps", {2'b0, r1, y1, g1, r2, y2, g2}, 8'b00100100);
    clr = 1'b1;
    // normal cycle; first edge also carries a tick that must be ignored
    start = 1'b1; tick = 1'b1; cyc(); tick = 1'b0;
    chk("start_tick", remain, 8'h25);
    chk("start_ph", {5'b0, phase}, 8'h01);
    ticks(24); chk("ag_last", remain, 8'h01);
    ticks(1);  chk("ay_ph", {5'b0, phase}, 8'h02); chk("ay_rem", remain, 8'h05);
    ticks(5);  chk("bg_ph", {5'b0, phase}, 8'h03); chk("bg_rem", remain, 8'h15);
    ticks(15); chk("by_ph", {5'b0, phase}, 8'h04); chk("by_rem", remain, 8'h05);
    ticks(5);  chk("ag2_ph", {5'b0, phase}, 8'h01); chk("ag2_rem", remain, 8'h25);
    // hold A in AG at 12
    ticks(13); chk("ha_pre", remain, 8'h12);
    stopa = 1'b1; ticks(40);
    chk("ha_ph", {5'b0, phase}, 8'h01); chk("ha_rem", remain, 8'h12);
    stopa = 1'b0; ticks(11);
    chk("ha_rel_ph", {5'b0, phase}, 8'h01); chk("ha_rel_rem", remain, 8'h01);
    ticks(1); chk("ha_ay", {5'b0, phase}, 8'h02);
    // hold A from BG
    ticks(5); ticks(2); chk("hab_pre", remain, 8'h13);
    stopa = 1'b1; cyc();
    chk("hab_by", {5'b0, phase}, 8'h04); chk("hab_rem", remain, 8'h05);
    ticks(5);  chk("hab_ag", {5'b0, phase}, 8'h01); chk("hab_ag_rem", remain, 8'h25);
    ticks(10); chk("hab_held", remain, 8'h25);
    stopa = 1'b0;
    // hold B from AG
    ticks(3); chk("hb_pre", remain, 8'h22);
    stopb = 1'b1; cyc();
    chk("hb_ay", {5'b0, phase}, 8'h02); chk("hb_rem", remain, 8'h05);
    ticks(5);  chk("hb_bg", {5'b0, phase}, 8'h03); chk("hb_bg_rem", remain, 8'h15);
    ticks(10); chk("hb_held", remain, 8'h15);
    stopb = 1'b0;
    // pause during BY at 03
    ticks(15); ticks(2);
    chk("pz_pre_ph", {5'b0, phase}, 8'h04); chk("pz_pre", remain, 8'h03);
    pause = 1'b1; ticks(10);
    chk("pz_ph", {5'b0, phase}, 8'h04); chk("pz_rem", remain, 8'h03);
    chk("pz_lamps", {2'b0, r1, y1, g1, r2, y2, g2}, 8'b00100010);
    pause = 1'b0; ticks(2); chk("pz_rel", remain, 8'h01);
    ticks(1); chk("pz_ag", {5'b0, phase}, 8'h01); chk("pz_ag_rem", remain, 8'h25);
    // asynchronous clear mid-AY
    ticks(25); ticks(2); chk("clr_pre", {5'b0, phase}, 8'h02);
    #2 clr = 1'b0;
    #1;
    m_ph = 0; m_cnt = 0;
    chk("clr_ph", {5'b0, phase}, 8'h00); chk("clr_rem", remain, 8'h00);
    chk("clr_lamps", {2'b0, r1, y1, g1, r2, y2, g2}, 8'b00100100);
    #1 clr = 1'b1;
    cyc(); chk("clr_restart", remain, 8'h25);
    // start=0 mid-BG
    ticks(25); ticks(5); ticks(3); chk("st_pre", {5'b0, phase}, 8'h03);
    start = 1'b0; cyc();
    chk("st_ph", {5'b0, phase}, 8'h00); chk("st_rem", remain, 8'h00);
    start = 1'b1; cyc();
    // random stimulus against the model
    repeat (3000) begin
      tick  = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 99) != 0);
      pause = ($urandom_range(0, 9) == 0);
      stopa = ($urandom_range(0, 11) == 0);
      stopb = ($urandom_range(0, 7) == 0);
      clr   = ($urandom_range(0, 199) != 0);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
